mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one data/instruction memory bus between the fetch stage (I port) and the memory stage (D port).
- The memory behind the bus has variable latency and signals completion with a req/ack handshake.
- Sequences each transfer, registers all bus outputs, and returns read data with a one-cycle ready pulse.
- Pipeline stall logic outside this block uses "req & ~ready" per port; this block itself contains no stall logic.

Parameters:
- STARVE_MAX, 4: consecutive lost arbitration rounds after which the I port is forced to win.
- WAIT_MAX, 255: bus_req cycles without bus_ack before the transfer is aborted. Legal range 1..255.

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
i_req  in  1  fetch request; held stable until i_ready
i_addr  in  32  fetch word address
i_rdata  out  32  fetched word; valid only while i_ready=1
i_ready  out  1  one-cycle completion pulse for the I port
d_req  in  1  data request; held stable until d_ready
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data address
d_wdata  in  32  store data, already lane-shifted
d_byteen  in  4  store byte enables
d_rdata  out  32  load data (raw word); 0 for stores
d_ready  out  1  one-cycle completion pulse for the D port
bus_req  out  1  bus request, registered
bus_we  out  1  bus write enable, registered
bus_addr  out  32  bus address, registered
bus_wdata  out  32  bus write data, registered
bus_byteen  out  4  bus byte enables, registered
bus_ack  in  1  memory completion; bus_rdata is valid in the same cycle
bus_rdata  in  32  memory read data
bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset state: every output is 0, FSM is IDLE, the wait counter and starve counter are 0.
- Reset applies at the edge even mid-transfer; bus_req falls at that edge.
- FSM states: IDLE, GRANT_I, GRANT_D, RESP_I, RESP_D.
- IDLE arbitration, evaluated at each edge:
  - If i_req=1 and starve counter = STARVE_MAX, grant I.
  - Else if d_req=1, grant D.
  - Else if i_req=1, grant I.
  - Else stay in IDLE.
- Starve counter:
  - Increments when D is granted while i_req=1, saturating at STARVE_MAX.
  - Clears when I is granted.
- Grant edge actions:
  - Latch the bus registers from the winning port and set bus_req=1.
  - For I: bus_we=0, bus_byteen=4'b1111, bus_wdata=0.
  - For D loads: bus_we=0, bus_byteen=4'b1111.
  - For D stores: bus_we=1, bus_byteen=d_byteen, bus_wdata=d_wdata.
- The bus registers are held constant for the whole GRANT state.
- GRANT_x:
  - The wait counter increments each cycle with bus_ack=0.
  - On bus_ack=1: clear bus_req, capture rdata, go to RESP_x.
    - I port captures bus_rdata.
    - D port captures bus_rdata for loads, 0 for stores.
  - If the wait counter reaches WAIT_MAX with no ack: clear bus_req, set rdata=0, bus_err=1, go to RESP_x.
  - If bus_ack and the timeout occur in the same cycle, ack wins and bus_err stays 0.
- RESP_x:
  - x_ready=1 for exactly this cycle, with x_rdata valid.
  - bus_err is also high in this cycle if the transfer was aborted.
  - No arbitration happens in RESP; the next edge goes to IDLE and clears ready, rdata and err.
- Latency:
  - req sampled at edge N gives bus_req high after N.
  - bus_ack in cycle N+k gives ready in cycle N+k+1.
  - Minimum latency from request to ready is 2 cycles (ack in the first GRANT cycle); the next grant is possible 1 cycle after RESP.
- Spurious bus_ack in IDLE or RESP is ignored.
- A request deasserted before ready is a protocol violation; the block still completes the latched transfer.
- Only one transfer is ever outstanding; there is no pipelining of bus requests.

Test Plan:
- D load alone: d_req=1, d_addr=0x0000_1004, bus_ack on the 3rd GRANT cycle with bus_rdata=0xDEAD_BEEF.
  -> bus_addr=0x1004, bus_we=0, bus_byteen=4'hF; d_ready pulses exactly 1 cycle with d_rdata=0xDEAD_BEEF; i_ready stays 0.
- Store: d_we=1, d_byteen=4'b0011, d_wdata=0x0000_ABCD, immediate ack.
  -> bus_we=1, bus_byteen=4'b0011, bus_wdata=0x0000_ABCD; d_ready pulse with d_rdata=0.
- Simultaneous i_req and d_req with STARVE_MAX=4, d_req reasserted continuously.
  -> D is granted 4 times, then I is granted on round 5 (i_addr on bus); the counter clears and D wins again.
- Timeout: WAIT_MAX=8, bus_ack held 0.
  -> bus_req high exactly 8 cycles then falls; the next cycle has i_ready=1, i_rdata=0, bus_err=1 for 1 cycle.
- Ack coincident with the timeout cycle.
  -> normal completion with bus_rdata, bus_err=0.
- Reset asserted during GRANT_D with bus_req=1.
  -> at the next edge all outputs are 0 and the FSM is IDLE; a later ack pulse produces no ready.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory bus between the fetch (I) and memory-stage (D)
// ports; one transfer outstanding at a time, all outputs registered.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned WAIT_MAX   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteen,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byteen,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    // Timeout fires in the WAIT_MAX-th GRANT cycle, whose counter value is WAIT_MAX-1.
    localparam logic [7:0]    WAIT_LAST  = 8'(WAIT_MAX - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GRANT_I = 3'd1;
    localparam logic [2:0] ST_GRANT_D = 3'd2;
    localparam logic [2:0] ST_RESP_I  = 3'd3;
    localparam logic [2:0] ST_RESP_D  = 3'd4;

    logic [2:0]    state_q,      state_d;
    logic [7:0]    wait_q,       wait_d;
    logic [SW-1:0] starve_q,     starve_d;
    logic          bus_req_q,    bus_req_d;
    logic          bus_we_q,     bus_we_d;
    logic [31:0]   bus_addr_q,   bus_addr_d;
    logic [31:0]   bus_wdata_q,  bus_wdata_d;
    logic [3:0]    bus_byteen_q, bus_byteen_d;
    logic          bus_err_q,    bus_err_d;
    logic [31:0]   i_rdata_q,    i_rdata_d;
    logic          i_ready_q,    i_ready_d;
    logic [31:0]   d_rdata_q,    d_rdata_d;
    logic          d_ready_q,    d_ready_d;

    logic          pick_i_s;
    logic          pick_d_s;

    // Arbitration: a starved I port beats D, otherwise D has priority.
    always_comb begin
        pick_i_s = i_req && ((starve_q == STARVE_LIM) || !d_req);
        pick_d_s = d_req && !pick_i_s;
    end

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        starve_d     = starve_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_byteen_d = bus_byteen_q;
        bus_err_d    = bus_err_q;
        i_rdata_d    = i_rdata_q;
        i_ready_d    = i_ready_q;
        d_rdata_d    = d_rdata_q;
        d_ready_d    = d_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_i_s) begin
                    state_d      = ST_GRANT_I;
                    starve_d     = {SW{1'b0}};
                    wait_d       = 8'd0;
                    bus_req_d    = 1'b1;
                    bus_we_d     = 1'b0;
                    bus_addr_d   = i_addr;
                    bus_wdata_d  = 32'h0000_0000;
                    bus_byteen_d = 4'b1111;
                end else if (pick_d_s) begin
                    state_d      = ST_GRANT_D;
                    wait_d       = 8'd0;
                    bus_req_d    = 1'b1;
                    bus_we_d     = d_we;
                    bus_addr_d   = d_addr;
                    bus_wdata_d  = d_we ? d_wdata : 32'h0000_0000;
                    bus_byteen_d = d_we ? d_byteen : 4'b1111;
                    if (i_req && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + SW'(1'b1);
                    end else begin
                        starve_d = starve_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_GRANT_I, ST_GRANT_D: begin
                // An ack arriving in the timeout cycle still completes normally.
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    wait_d    = 8'd0;
                    if (state_q == ST_GRANT_I) begin
                        state_d   = ST_RESP_I;
                        i_ready_d = 1'b1;
                        i_rdata_d = bus_rdata;
                    end else begin
                        state_d   = ST_RESP_D;
                        d_ready_d = 1'b1;
                        d_rdata_d = bus_we_q ? 32'h0000_0000 : bus_rdata;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    wait_d    = 8'd0;
                    if (state_q == ST_GRANT_I) begin
                        state_d   = ST_RESP_I;
                        i_ready_d = 1'b1;
                        i_rdata_d = 32'h0000_0000;
                    end else begin
                        state_d   = ST_RESP_D;
                        d_ready_d = 1'b1;
                        d_rdata_d = 32'h0000_0000;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            ST_RESP_I, ST_RESP_D: begin
                state_d   = ST_IDLE;
                i_ready_d = 1'b0;
                d_ready_d = 1'b0;
                i_rdata_d = 32'h0000_0000;
                d_rdata_d = 32'h0000_0000;
                bus_err_d = 1'b0;
            end

            default: begin
                state_d   = ST_IDLE;
                wait_d    = 8'd0;
                bus_req_d = 1'b0;
                bus_err_d = 1'b0;
                i_ready_d = 1'b0;
                d_ready_d = 1'b0;
                i_rdata_d = 32'h0000_0000;
                d_rdata_d = 32'h0000_0000;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wait_q       <= 8'd0;
            starve_q     <= {SW{1'b0}};
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'h0000_0000;
            bus_wdata_q  <= 32'h0000_0000;
            bus_byteen_q <= 4'b0000;
            bus_err_q    <= 1'b0;
            i_rdata_q    <= 32'h0000_0000;
            i_ready_q    <= 1'b0;
            d_rdata_q    <= 32'h0000_0000;
            d_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            starve_q     <= starve_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_byteen_q <= bus_byteen_d;
            bus_err_q    <= bus_err_d;
            i_rdata_q    <= i_rdata_d;
            i_ready_q    <= i_ready_d;
            d_rdata_q    <= d_rdata_d;
            d_ready_q    <= d_ready_d;
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_byteen = bus_byteen_q;
    assign bus_err    = bus_err_q;
    assign i_rdata    = i_rdata_q;
    assign i_ready    = i_ready_q;
    assign d_rdata    = d_rdata_q;
    assign d_ready    = d_ready_q;

endmodule
